move_scan_ctrl: RTL and testbench

- Sequences one shared combinational neighbour-shift unit to compute legal step and jump source masks for the side to move.
- Covers all four diagonal directions on the 32-square board.
- Sits between the game-logic CPU op, which starts a scan and reads the masks, and the board shifter in the ALU.
- Fixed latency makes the op schedulable as a multi-cycle ALU instruction.

---
 rtl/move_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_move_scan_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/move_scan_ctrl.sv
// -----------------------------------------------------------------------------
// move_scan_ctrl
//
// Purpose:
//   Sequences one external combinational neighbour-shift unit to compute the
//   legal step and jump source masks for the side to move. The board has 32
//   squares in 8 rows of 4. Square s sits at row s/4 and column s%4, with
//   square 0 at the top-left.
//   Each of the four diagonal directions takes three single-cycle shifter
//   passes:
//     S1 = shift(d, occ)   - first neighbour occupied
//     S2 = shift(d, S1)    - second neighbour (landing square) occupied
//     S3 = shift(d, opp)   - first neighbour holds an opponent piece
//   A result clears to zero when a scan is accepted and then holds until the
//   next accepted start.
//
// Parameters:
//   SKIP_EMPTY_DIRS - 1: a direction with no permitted piece costs no cycles.
//
// Ports:
//   clock      in   system clock
//   resetn     in   synchronous active-low reset
//   start      in   scan request, taken only while busy=0
//   own        in   [31:0] own pieces
//   opp        in   [31:0] opponent pieces
//   kings      in   [31:0] king flags (only own & kings matters)
//   side       in   0: men move up (UR, UL), 1: men move down (DR, DL)
//   shift_dir  out  [1:0] shifter direction 0=UR 1=UL 2=DR 3=DL
//   shift_in   out  [31:0] shifter operand
//   shift_out  in   [31:0] shifter result, same cycle
//   busy       out  scan in progress
//   done       out  one-cycle pulse when results are valid
//   step_dirs  out  [127:0] per-direction step sources, field d = [32d+31:32d]
//   jump_dirs  out  [127:0] per-direction jump sources
//   step_mask  out  [31:0] OR of the step_dirs fields
//   jump_mask  out  [31:0] OR of the jump_dirs fields
//   any_jump   out  capture is forced
// -----------------------------------------------------------------------------
module move_scan_ctrl #(
    parameter bit SKIP_EMPTY_DIRS = 1'b0
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [31:0]  own,
    input  logic [31:0]  opp,
    input  logic [31:0]  kings,
    input  logic         side,
    output logic [1:0]   shift_dir,
    output logic [31:0]  shift_in,
    input  logic [31:0]  shift_out,
    output logic         busy,
    output logic         done,
    output logic [127:0] step_dirs,
    output logic [127:0] jump_dirs,
    output logic [31:0]  step_mask,
    output logic [31:0]  jump_mask,
    output logic         any_jump
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P0   = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [1:0]   r_dir;
    logic [1:0]   w_next_dir;
    logic [2:0]   w_next_d;
    logic [1:0]   w_shift_dir;
    logic [31:0]  w_shift_in;
    logic [31:0]  w_p_cur;

    logic [31:0]  r_own;
    logic [31:0]  r_opp;
    logic [31:0]  r_kings;
    logic         r_side;
    logic [31:0]  r_occ;
    logic [31:0]  r_s1;
    logic [31:0]  r_s2;
    logic         r_busy;
    logic         r_done;
    logic [127:0] r_step_dirs;
    logic [127:0] r_jump_dirs;
    logic [31:0]  r_step_mask;
    logic [31:0]  r_jump_mask;
    logic         r_any_jump;

    // Pieces allowed to move in direction d. Men only go forward: up for
    // side 0 (d = 0, 1) and down for side 1 (d = 2, 3). Kings go any way.
    function automatic logic [31:0] perm_mask(input logic [1:0] d, input logic sd,
                                              input logic [31:0] ow, input logic [31:0] kg);
        logic men_ok;
        men_ok = (d[1] == sd);
        if (men_ok) begin
            return ow;
        end else begin
            return ow & kg;
        end
    endfunction

    // Smallest direction >= start_d that needs passes. Bit 2 set means none
    // remain. Without skipping, every direction counts.
    function automatic logic [2:0] next_dir(input logic [2:0] start_d, input logic sd,
                                            input logic [31:0] ow, input logic [31:0] kg);
        logic [2:0] res;
        res = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if ((3'(i) >= start_d) &&
                (!SKIP_EMPTY_DIRS || (perm_mask(2'(i), sd, ow, kg) != 32'd0))) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

    assign w_p_cur = perm_mask(r_dir, r_side, r_own, r_kings);

    // State register: phase and current direction.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_dir   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_dir   <= w_next_dir;
        end
    end

    // Next-state logic and shifter drive.
    always_comb begin
        w_next_state = r_state;
        w_next_dir   = r_dir;
        w_next_d     = 3'd0;
        w_shift_dir  = 2'd0;
        w_shift_in   = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // The decision uses the raw inputs, so an all-empty
                    // skip scan goes straight to FIN.
                    w_next_d = next_dir(3'd0, side, own, kings);
                    if (w_next_d[2]) begin
                        w_next_state = ST_FIN;
                        w_next_dir   = 2'd0;
                    end else begin
                        w_next_state = ST_P0;
                        w_next_dir   = w_next_d[1:0];
                    end
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_dir   = r_dir;
                end
            end
            ST_P0: begin
                w_shift_dir  = r_dir;
                w_shift_in   = r_occ;
                w_next_state = ST_P1;
            end
            ST_P1: begin
                w_shift_dir  = r_dir;
                w_shift_in   = r_s1;
                w_next_state = ST_P2;
            end
            ST_P2: begin
                w_shift_dir = r_dir;
                w_shift_in  = r_opp;
                w_next_d    = next_dir({1'b0, r_dir} + 3'd1, r_side, r_own, r_kings);
                if (w_next_d[2]) begin
                    w_next_state = ST_FIN;
                    w_next_dir   = 2'd0;
                end else begin
                    w_next_state = ST_P0;
                    w_next_dir   = w_next_d[1:0];
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
                w_next_dir   = 2'd0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_dir   = 2'd0;
            end
        endcase
    end

    // Datapath: operand latch, pass captures, per-direction results, summary.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_own       <= 32'd0;
            r_opp       <= 32'd0;
            r_kings     <= 32'd0;
            r_side      <= 1'b0;
            r_occ       <= 32'd0;
            r_s1        <= 32'd0;
            r_s2        <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_step_dirs <= 128'd0;
            r_jump_dirs <= 128'd0;
            r_step_mask <= 32'd0;
            r_jump_mask <= 32'd0;
            r_any_jump  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_own       <= own;
                        r_opp       <= opp;
                        r_kings     <= kings;
                        r_side      <= side;
                        r_occ       <= own | opp;
                        r_busy      <= 1'b1;
                        r_step_dirs <= 128'd0;
                        r_jump_dirs <= 128'd0;
                        r_step_mask <= 32'd0;
                        r_jump_mask <= 32'd0;
                        r_any_jump  <= 1'b0;
                    end
                end
                ST_P0: begin
                    r_s1 <= shift_out;
                end
                ST_P1: begin
                    r_s2 <= shift_out;
                end
                ST_P2: begin
                    // shift_out is S3 here. It is used directly and not stored.
                    r_step_dirs[{r_dir, 5'd0} +: 32] <= w_p_cur & ~r_s1;
                    r_jump_dirs[{r_dir, 5'd0} +: 32] <= w_p_cur & shift_out & ~r_s2;
                end
                ST_FIN: begin
                    r_step_mask <= r_step_dirs[31:0] | r_step_dirs[63:32] |
                                   r_step_dirs[95:64] | r_step_dirs[127:96];
                    r_jump_mask <= r_jump_dirs[31:0] | r_jump_dirs[63:32] |
                                   r_jump_dirs[95:64] | r_jump_dirs[127:96];
                    r_any_jump  <= |(r_jump_dirs[31:0] | r_jump_dirs[63:32] |
                                     r_jump_dirs[95:64] | r_jump_dirs[127:96]);
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign shift_dir = w_shift_dir;
    assign shift_in  = w_shift_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign step_dirs = r_step_dirs;
    assign jump_dirs = r_jump_dirs;
    assign step_mask = r_step_mask;
    assign jump_mask = r_jump_mask;
    assign any_jump  = r_any_jump;

endmodule

// File: tb/tb_move_scan_ctrl.sv
module tb_move_scan_ctrl;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic [31:0]  own_i = 32'd0;
    logic [31:0]  opp_i = 32'd0;
    logic [31:0]  kings_i = 32'd0;
    logic         side_i = 1'b0;

    logic [1:0]   sh_dir0, sh_dir1;
    logic [31:0]  sh_in0, sh_in1, sh_out0, sh_out1;
    logic         busy0, busy1, done0, done1;
    logic [127:0] sdirs0, sdirs1, jdirs0, jdirs1;
    logic [31:0]  smask0, smask1, jmask0, jmask1;
    logic         anyj0, anyj1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Board shifter: out[s] = in[neighbour(d, s)], off-board reads as 1.
    function automatic logic [31:0] shift_model(input logic [1:0] d, input logic [31:0] v);
        logic [31:0] r;
        int row, col, nr, nc;
        for (int s = 0; s < 32; s++) begin
            row = s / 4;
            col = s % 4;
            nr  = d[1] ? row + 1 : row - 1;
            nc  = (d == 2'd0 || d == 2'd2) ? col + 1 : col - 1;
            if (nr < 0 || nr > 7 || nc < 0 || nc > 3) r[s] = 1'b1;
            else r[s] = v[nr * 4 + nc];
        end
        return r;
    endfunction

    assign sh_out0 = shift_model(sh_dir0, sh_in0);
    assign sh_out1 = shift_model(sh_dir1, sh_in1);

    move_scan_ctrl #(.SKIP_EMPTY_DIRS(1'b0)) u_dut0 (
        .clock(clk), .resetn(resetn), .start(start0),
        .own(own_i), .opp(opp_i), .kings(kings_i), .side(side_i),
        .shift_dir(sh_dir0), .shift_in(sh_in0), .shift_out(sh_out0),
        .busy(busy0), .done(done0), .step_dirs(sdirs0), .jump_dirs(jdirs0),
        .step_mask(smask0), .jump_mask(jmask0), .any_jump(anyj0)
    );

    move_scan_ctrl #(.SKIP_EMPTY_DIRS(1'b1)) u_dut1 (
        .clock(clk), .resetn(resetn), .start(start1),
        .own(own_i), .opp(opp_i), .kings(kings_i), .side(side_i),
        .shift_dir(sh_dir1), .shift_in(sh_in1), .shift_out(sh_out1),
        .busy(busy1), .done(done1), .step_dirs(sdirs1), .jump_dirs(jdirs1),
        .step_mask(smask1), .jump_mask(jmask1), .any_jump(anyj1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts a scan at the current negedge and returns the number of edges
    // from the accept edge to the first cycle where done is visible.
    task automatic scan(input bit which, input logic [31:0] o, input logic [31:0] p,
                        input logic [31:0] k, input logic sd, output int lat);
        own_i = o; opp_i = p; kings_i = k; side_i = sd;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        lat = 0;
        while (!(which ? done1 : done0) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_res(input string t, input bit which,
                             input logic [127:0] e_sd, input logic [127:0] e_jd,
                             input logic [31:0] e_sm, input logic [31:0] e_jm, input logic e_aj);
        check($sformatf("%s_step_dirs", t), which ? sdirs1 : sdirs0, e_sd);
        check($sformatf("%s_jump_dirs", t), which ? jdirs1 : jdirs0, e_jd);
        check($sformatf("%s_step_mask", t), 128'(which ? smask1 : smask0), 128'(e_sm));
        check($sformatf("%s_jump_mask", t), 128'(which ? jmask1 : jmask0), 128'(e_jm));
        check($sformatf("%s_any_jump", t), 128'(which ? anyj1 : anyj0), 128'(e_aj));
        check($sformatf("%s_busy_done", t), 128'(which ? busy1 : busy0), 128'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        int first_done;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy0), 128'd0);
        check("rst_done", 128'(done0), 128'd0);
        check_res("rst", 1'b0, 128'd0, 128'd0, 32'd0, 32'd0, 1'b0);
        check("rst_shift_in", 128'(sh_in0), 128'd0);
        check("rst_shift_dir", 128'(sh_dir0), 128'd0);
        resetn = 1'b1;
        @(negedge clk);

        // T1: lone man on square 25, moving up.
        scan(1'b0, 32'h0200_0000, 32'd0, 32'd0, 1'b0, lat);
        check("t1_latency", 128'(lat), 128'd13);
        check_res("t1", 1'b0, 128'h0000_0000_0000_0000_0200_0000_0200_0000, 128'd0,
                  32'h0200_0000, 32'd0, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", 128'(done0), 128'd0);

        // T2: opponent on 22, landing 19 empty -> UR jump. Back-to-back start.
        scan(1'b0, 32'h0200_0000, 32'h0040_0000, 32'd0, 1'b0, lat);
        check("t2_latency", 128'(lat), 128'd13);
        check_res("t2", 1'b0, 128'h0000_0000_0000_0000_0200_0000_0000_0000,
                  128'h0000_0000_0000_0000_0000_0000_0200_0000,
                  32'h0200_0000, 32'h0200_0000, 1'b1);

        // T3: landing 19 occupied -> no jump, UL step only.
        scan(1'b0, 32'h0200_0000, 32'h0048_0000, 32'd0, 1'b0, lat);
        check("t3_latency", 128'(lat), 128'd13);
        check_res("t3", 1'b0, 128'h0000_0000_0000_0000_0200_0000_0000_0000, 128'd0,
                  32'h0200_0000, 32'd0, 1'b0);

        // T4: king on 28 (bottom-left corner): only UR stays on board.
        scan(1'b0, 32'h1000_0000, 32'd0, 32'h1000_0000, 1'b0, lat);
        check_res("t4", 1'b0, 128'h0000_0000_0000_0000_0000_0000_1000_0000, 128'd0,
                  32'h1000_0000, 32'd0, 1'b0);

        // T5: side 1, man on 0: DR step only.
        scan(1'b0, 32'h0000_0001, 32'd0, 32'd0, 1'b1, lat);
        check_res("t5", 1'b0, 128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'd0,
                  32'h0000_0001, 32'd0, 1'b0);

        // T6: side 1, man on 0, opponent on 5, landing 10 empty -> DR jump.
        scan(1'b0, 32'h0000_0001, 32'h0000_0020, 32'd0, 1'b1, lat);
        check_res("t6", 1'b0, 128'd0, 128'h0000_0000_0000_0001_0000_0000_0000_0000,
                  32'd0, 32'h0000_0001, 1'b1);

        // Protocol: start during a scan is ignored.
        own_i = 32'h0200_0000; opp_i = 32'd0; kings_i = 32'd0; side_i = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("busy_after_accept", 128'(busy0), 128'd1);
        ndone = 0; first_done = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 3) begin
                own_i = 32'h0000_0001; side_i = 1'b1; start0 = 1'b1;
            end else begin
                start0 = 1'b0;
            end
            @(negedge clk);
            if (done0) begin
                ndone++;
                if (first_done == 0) first_done = n;
            end
        end
        check("busy_start_done_count", 128'(ndone), 128'd1);
        check("busy_start_done_cycle", 128'(first_done), 128'd13);
        check_res("busy_start", 1'b0, 128'h0000_0000_0000_0000_0200_0000_0200_0000, 128'd0,
                  32'h0200_0000, 32'd0, 1'b0);

        // SKIP_EMPTY_DIRS=1: no own pieces -> done 1 cycle after accept.
        scan(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, lat);
        check("skip_empty_latency", 128'(lat), 128'd1);
        check_res("skip_empty", 1'b1, 128'd0, 128'd0, 32'd0, 32'd0, 1'b0);

        // SKIP_EMPTY_DIRS=1: man on 25 moving up -> two directions, 7 cycles.
        scan(1'b1, 32'h0200_0000, 32'd0, 32'd0, 1'b0, lat);
        check("skip_two_latency", 128'(lat), 128'd7);
        check_res("skip_two", 1'b1, 128'h0000_0000_0000_0000_0200_0000_0200_0000, 128'd0,
                  32'h0200_0000, 32'd0, 1'b0);

        // Reset mid-scan: aborted, cleared, no done.
        @(negedge clk);
        own_i = 32'h0200_0000; opp_i = 32'h0040_0000; kings_i = 32'd0; side_i = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_busy", 128'(busy0), 128'd0);
        check("midrst_done", 128'(done0), 128'd0);
        check("midrst_step_dirs", sdirs0, 128'd0);
        check("midrst_jump_dirs", jdirs0, 128'd0);
        check("midrst_masks", {64'd0, smask0, jmask0}, 128'd0);
        resetn = 1'b1;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check("midrst_no_done", 128'(ndone), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
